csr_file: RTL

- Control/status register file; the consumer end of the WB-stage exception report (wb_ex, wb_ecode, wb_esubcode).
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL, TICLR.
- Performs exception-entry and ertn-return state updates, serves csrrd/csrwr/csrxchg, and runs the stable-counter timer.
- Feeds has_int back to the exception prioritizer; supplies the flush target (EENTRY or ERA) to IF.

---
 rtl/csr_file_pkg.sv | 43 ++++
 rtl/csr_file_if.sv | 37 +++
 rtl/csr_timer.sv | 51 +++++
 rtl/csr_file.sv | 129 ++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Shared constants for the CSR file: addresses, exception codes and field positions.
package csr_file_pkg;

  typedef logic [13:0] csr_addr_t;

  localparam csr_addr_t CSR_CRMD   = 14'h000;
  localparam csr_addr_t CSR_PRMD   = 14'h001;
  localparam csr_addr_t CSR_ECFG   = 14'h004;
  localparam csr_addr_t CSR_ESTAT  = 14'h005;
  localparam csr_addr_t CSR_ERA    = 14'h006;
  localparam csr_addr_t CSR_BADV   = 14'h007;
  localparam csr_addr_t CSR_EENTRY = 14'h00C;
  localparam csr_addr_t CSR_SAVE0  = 14'h030;
  localparam csr_addr_t CSR_SAVE1  = 14'h031;
  localparam csr_addr_t CSR_SAVE2  = 14'h032;
  localparam csr_addr_t CSR_SAVE3  = 14'h033;
  localparam csr_addr_t CSR_TID    = 14'h040;
  localparam csr_addr_t CSR_TCFG   = 14'h041;
  localparam csr_addr_t CSR_TVAL   = 14'h042;
  localparam csr_addr_t CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam int CRMD_PLV_LSB = 0;
  localparam int CRMD_IE      = 2;
  localparam int CRMD_DA      = 3;
  localparam int CRMD_PG      = 4;
  localparam int PRMD_PIE     = 2;
  localparam int ESTAT_IS_TI  = 11;
  localparam int ESTAT_IS_IPI = 12;
  localparam int TCFG_EN      = 0;
  localparam int TCFG_PERIOD  = 1;
  localparam int TCFG_INIT_LSB = 2;

  // ECFG.LIE bit 10 is reserved.
  localparam logic [12:0] LIE_WMASK = 13'h1BFF;

endpackage

// File: rtl/csr_file_if.sv
// Pipeline-to-CSR bus: read/write port, WB exception report, interrupts and flush targets.
interface csr_file_if;
  import csr_file_pkg::*;

  logic        csr_re;
  csr_addr_t   csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [7:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_out;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, era_out
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, era_out
  );

endinterface

// File: rtl/csr_timer.sv
// Stable-counter timer: TCFG register, TVAL down-counter with one-shot/periodic reload.
module csr_timer
  import csr_file_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we_i,
  input  logic [31:0]        tcfg_wdata_i,
  output logic [TIMER_W-1:0] tcfg_o,
  output logic [TIMER_W-1:0] tval_o,
  output logic               timer_set_o
);

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic [TIMER_W-1:0] reload;

  // Decisions use the post-write TCFG so a write that clears En freezes TVAL at once.
  always_comb begin
    tcfg_d      = tcfg_we_i ? tcfg_wdata_i[TIMER_W-1:0] : tcfg_q;
    reload      = {tcfg_d[TIMER_W-1:TCFG_INIT_LSB], 2'b00};
    tval_d      = tval_q;
    timer_set_o = 1'b0;
    if (tcfg_we_i && tcfg_d[TCFG_EN]) begin
      tval_d = reload;
    end else if (tcfg_d[TCFG_EN]) begin
      if (tval_q != '0) begin
        tval_d      = tval_q - TIMER_W'(1);
        timer_set_o = (tval_q == TIMER_W'(1));
      end else if (tcfg_d[TCFG_PERIOD]) begin
        tval_d = reload;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tcfg_o = tcfg_q;
  assign tval_o = tval_q;

endmodule

// File: rtl/csr_file.sv
// CSR file: exception entry/return state, csrrd/csrwr/csrxchg access, interrupt pending logic.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0,
  parameter int          TIMER_W   = 32
) (
  input logic         clk,
  input logic         reset,
  csr_file_if.slave   bus
);

  logic [4:0]  crmd_q, crmd_d;
  logic [2:0]  prmd_q, prmd_d;
  logic [12:0] lie_q, lie_d;
  logic [12:0] is_q, is_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, tid_q, tid_d;
  logic [25:0] eentry_q, eentry_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic [31:0]        rdata, wdat;
  logic [TIMER_W-1:0] tcfg, tval;
  logic               timer_set, tcfg_we, ticlr_clr;
  logic               unused_ok;

  assign unused_ok = bus.csr_re;

  always_comb begin
    rdata = 32'h0;
    case (bus.csr_num)
      CSR_CRMD:   rdata = {27'h0, crmd_q};
      CSR_PRMD:   rdata = {29'h0, prmd_q};
      CSR_ECFG:   rdata = {19'h0, lie_q};
      CSR_ESTAT:  rdata = {1'b0, esub_q, ecode_q, 3'b000, is_q};
      CSR_ERA:    rdata = era_q;
      CSR_BADV:   rdata = badv_q;
      CSR_EENTRY: rdata = {eentry_q, 6'h00};
      CSR_SAVE0:  rdata = save_q[0];
      CSR_SAVE1:  rdata = save_q[1];
      CSR_SAVE2:  rdata = save_q[2];
      CSR_SAVE3:  rdata = save_q[3];
      CSR_TID:    rdata = tid_q;
      CSR_TCFG:   rdata = 32'(tcfg);
      CSR_TVAL:   rdata = 32'(tval);
      default:    rdata = 32'h0;
    endcase
  end

  // The read mux supplies the old value, so one merge serves every writable CSR.
  assign wdat      = (rdata & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign tcfg_we   = bus.csr_we && (bus.csr_num == CSR_TCFG);
  assign ticlr_clr = bus.csr_we && (bus.csr_num == CSR_TICLR) &&
                     bus.csr_wvalue[0] && bus.csr_wmask[0];

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .tcfg_we_i    (tcfg_we),
    .tcfg_wdata_i (wdat),
    .tcfg_o       (tcfg),
    .tval_o       (tval),
    .timer_set_o  (timer_set)
  );

  // Later assignments override earlier ones: csr_we < ertn < wb_ex.
  always_comb begin
    crmd_d = crmd_q;  prmd_d = prmd_q;  lie_d = lie_q;  is_d = is_q;
    ecode_d = ecode_q;  esub_d = esub_q;  era_d = era_q;  badv_d = badv_q;
    eentry_d = eentry_q;  tid_d = tid_q;  save_d = save_q;
    if (bus.csr_we) begin
      case (bus.csr_num)
        CSR_CRMD:   crmd_d    = wdat[4:0];
        CSR_PRMD:   prmd_d    = wdat[2:0];
        CSR_ECFG:   lie_d     = wdat[12:0] & LIE_WMASK;
        CSR_ESTAT:  is_d[1:0] = wdat[1:0];
        CSR_ERA:    era_d     = wdat;
        CSR_BADV:   badv_d    = wdat;
        CSR_EENTRY: eentry_d  = wdat[31:6];
        CSR_SAVE0:  save_d[0] = wdat;
        CSR_SAVE1:  save_d[1] = wdat;
        CSR_SAVE2:  save_d[2] = wdat;
        CSR_SAVE3:  save_d[3] = wdat;
        CSR_TID:    tid_d     = wdat;
        default:    ;
      endcase
    end
    if (bus.ertn_flush && !bus.wb_ex) begin
      crmd_d[CRMD_IE:CRMD_PLV_LSB] = prmd_q;
    end
    if (bus.wb_ex) begin
      prmd_d                       = crmd_q[CRMD_IE:CRMD_PLV_LSB];
      crmd_d[CRMD_IE:CRMD_PLV_LSB] = 3'b000;
      ecode_d                      = bus.wb_ecode;
      esub_d                       = {1'b0, bus.wb_esubcode};
      era_d                        = bus.wb_pc;
      if (bus.wb_ecode == ECODE_ADEF)     badv_d = bus.wb_pc;
      else if (bus.wb_ecode == ECODE_ALE) badv_d = bus.wb_vaddr;
      else                                badv_d = badv_q;
    end
    is_d[9:2]          = bus.hw_int_in;
    is_d[10]           = 1'b0;
    is_d[ESTAT_IS_IPI] = bus.ipi_int_in;
    if (timer_set)      is_d[ESTAT_IS_TI] = 1'b1;
    else if (ticlr_clr) is_d[ESTAT_IS_TI] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_q <= 5'b01000;  prmd_q <= '0;  lie_q <= '0;  is_q <= '0;
      ecode_q <= '0;  esub_q <= '0;  era_q <= '0;  badv_q <= '0;
      eentry_q <= '0;  tid_q <= TID_RESET;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d;  prmd_q <= prmd_d;  lie_q <= lie_d;  is_q <= is_d;
      ecode_q <= ecode_d;  esub_q <= esub_d;  era_q <= era_d;  badv_q <= badv_d;
      eentry_q <= eentry_d;  tid_q <= tid_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  assign bus.csr_rvalue = rdata;
  assign bus.has_int    = crmd_q[CRMD_IE] & (|(is_q & lie_q));
  assign bus.ex_entry   = {eentry_q, 6'h00};
  assign bus.era_out    = era_q;

endmodule
